// File: rtl/parking_lot_ctrl.sv
// Occupancy controller for a car park shared by university and free cars.
// Capacity moves from university to free spaces in hourly steps in the afternoon.
module parking_lot_ctrl #(
    parameter int CYCLES_PER_HOUR  = 256,
    parameter int START_HOUR       = 8,
    parameter int UNI_CAP_BASE     = 500,
    parameter int FREE_CAP_BASE    = 200,
    parameter int CAP_STEP         = 50,
    parameter int SHIFT_FIRST_HOUR = 13,
    parameter int SHIFT_LAST_HOUR  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_entered,
    input  logic       is_uni_car_entered,
    input  logic       car_exited,
    input  logic       is_uni_car_exited,
    output logic [8:0] uni_parked_car,
    output logic [8:0] parked_car,
    output logic [8:0] uni_vacated_space,
    output logic [8:0] vacated_space,
    output logic       uni_is_vacated_space,
    output logic       is_vacated_space,
    output logic       illegal_enter,
    output logic       illegal_exit
);

    localparam int CW = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;
    localparam logic [CW-1:0] LAST_CYCLE = CW'(CYCLES_PER_HOUR - 1);
    localparam logic [4:0]    START_HR   = 5'(START_HOUR);
    localparam logic [4:0]    LAST_HR    = 5'd23;

    logic [CW-1:0] cycle_q, cycle_d;
    logic [4:0]    hour_q, hour_d;
    logic [8:0]    uniParked_q, uniParked_d;
    logic [8:0]    freeParked_q, freeParked_d;
    logic          illegalEnter_q, illegalEnter_d;
    logic          illegalExit_q, illegalExit_d;

    logic [8:0] uniCap, freeCap, uniVac, freeVac;
    logic       uniEnterOk, freeEnterOk, uniExitOk, freeExitOk;
    int         shiftSteps;

    // Vacancy saturates at zero when a capacity shift leaves more cars than spaces.
    always_comb begin
        shiftSteps = 0;
        for (int h = SHIFT_FIRST_HOUR; h <= SHIFT_LAST_HOUR; h++) begin
            if (int'(hour_q) >= h) shiftSteps = shiftSteps + 1;
        end
        uniCap  = 9'(UNI_CAP_BASE - shiftSteps * CAP_STEP);
        freeCap = 9'(FREE_CAP_BASE + shiftSteps * CAP_STEP);
        uniVac  = (uniCap > uniParked_q) ? (uniCap - uniParked_q) : '0;
        freeVac = (freeCap > freeParked_q) ? (freeCap - freeParked_q) : '0;
    end

    always_comb begin
        uniEnterOk  = car_entered && is_uni_car_entered && (uniVac != '0);
        freeEnterOk = car_entered && !is_uni_car_entered && (freeVac != '0);
        uniExitOk   = car_exited && is_uni_car_exited && (uniParked_q != '0);
        freeExitOk  = car_exited && !is_uni_car_exited && (freeParked_q != '0);

        uniParked_d    = uniParked_q + 9'(uniEnterOk) - 9'(uniExitOk);
        freeParked_d   = freeParked_q + 9'(freeEnterOk) - 9'(freeExitOk);
        illegalEnter_d = car_entered && !(uniEnterOk || freeEnterOk);
        illegalExit_d  = car_exited && !(uniExitOk || freeExitOk);

        cycle_d = cycle_q + 1'b1;
        hour_d  = hour_q;
        if (cycle_q == LAST_CYCLE) begin
            cycle_d = '0;
            if (hour_q != LAST_HR) hour_d = hour_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q        <= '0;
            hour_q         <= START_HR;
            uniParked_q    <= '0;
            freeParked_q   <= '0;
            illegalEnter_q <= 1'b0;
            illegalExit_q  <= 1'b0;
        end else begin
            cycle_q        <= cycle_d;
            hour_q         <= hour_d;
            uniParked_q    <= uniParked_d;
            freeParked_q   <= freeParked_d;
            illegalEnter_q <= illegalEnter_d;
            illegalExit_q  <= illegalExit_d;
        end
    end

    assign uni_parked_car       = uniParked_q;
    assign parked_car           = freeParked_q;
    assign uni_vacated_space    = uniVac;
    assign vacated_space        = freeVac;
    assign uni_is_vacated_space = (uniVac != '0);
    assign is_vacated_space     = (freeVac != '0);
    assign illegal_enter        = illegalEnter_q;
    assign illegal_exit         = illegalExit_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Testbench for parking_lot_ctrl: directed scenarios plus random traffic
// checked every cycle against a reference model based on elapsed edges.
module tb_parking_lot_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic [8:0] uni_parked_car, parked_car, uni_vacated_space, vacated_space;
    logic       uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit;

    int compareCount  = 0;
    int mismatchCount = 0;

    int mUni, mFree, mEdges;
    int mIllEn, mIllEx;

    parking_lot_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .car_entered         (car_entered),
        .is_uni_car_entered  (is_uni_car_entered),
        .car_exited          (car_exited),
        .is_uni_car_exited   (is_uni_car_exited),
        .uni_parked_car      (uni_parked_car),
        .parked_car          (parked_car),
        .uni_vacated_space   (uni_vacated_space),
        .vacated_space       (vacated_space),
        .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space    (is_vacated_space),
        .illegal_enter       (illegal_enter),
        .illegal_exit        (illegal_exit)
    );

    always #5 clk = ~clk;

    function automatic int hourOf(input int edges);
        int h;
        h = 8 + edges / 256;
        return (h > 23) ? 23 : h;
    endfunction

    function automatic int shiftsAt(input int hr);
        int k;
        k = 0;
        for (int h = 13; h <= 16; h++) if (h <= hr) k++;
        return k;
    endfunction

    function automatic int uniCapAt(input int hr);
        return 500 - 50 * shiftsAt(hr);
    endfunction

    function automatic int freeCapAt(input int hr);
        return 200 + 50 * shiftsAt(hr);
    endfunction

    function automatic int vacancy(input int cap, input int parked);
        return (parked < cap) ? cap - parked : 0;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed != expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d (edge %0d)", tag, observed, expected, mEdges);
        end
    endtask

    task automatic checkAll();
        int hr, uv, fv;
        hr = hourOf(mEdges);
        uv = vacancy(uniCapAt(hr), mUni);
        fv = vacancy(freeCapAt(hr), mFree);
        checkOutput("uniParked", int'(uni_parked_car), mUni);
        checkOutput("freeParked", int'(parked_car), mFree);
        checkOutput("uniVacated", int'(uni_vacated_space), uv);
        checkOutput("freeVacated", int'(vacated_space), fv);
        checkOutput("uniIsVacated", int'(uni_is_vacated_space), (uv != 0) ? 1 : 0);
        checkOutput("freeIsVacated", int'(is_vacated_space), (fv != 0) ? 1 : 0);
        checkOutput("illegalEnter", int'(illegal_enter), mIllEn);
        checkOutput("illegalExit", int'(illegal_exit), mIllEx);
    endtask

    task automatic modelReset();
        mUni = 0; mFree = 0; mEdges = 0; mIllEn = 0; mIllEx = 0;
    endtask

    // Entry uses the vacancy seen before the edge, so a same-cycle exit gives no credit.
    task automatic modelEdge(input bit en, input bit enUni, input bit ex, input bit exUni);
        int hr, uv, fv;
        bit okEn, okEx;
        hr = hourOf(mEdges);
        uv = vacancy(uniCapAt(hr), mUni);
        fv = vacancy(freeCapAt(hr), mFree);
        okEn = en && ((enUni ? uv : fv) > 0);
        okEx = ex && ((exUni ? mUni : mFree) > 0);
        if (okEn) begin
            if (enUni) mUni++; else mFree++;
        end
        if (okEx) begin
            if (exUni) mUni--; else mFree--;
        end
        mIllEn = (en && !okEn) ? 1 : 0;
        mIllEx = (ex && !okEx) ? 1 : 0;
        mEdges++;
    endtask

    task automatic applyStimulus(input bit en, input bit enUni, input bit ex, input bit exUni);
        car_entered        = en;
        is_uni_car_entered = enUni;
        car_exited         = ex;
        is_uni_car_exited  = exUni;
        @(posedge clk);
        modelEdge(en, enUni, ex, exUni);
        @(negedge clk);
        checkAll();
    endtask

    task automatic doReset();
        car_entered = 0; is_uni_car_entered = 0; car_exited = 0; is_uni_car_exited = 0;
        reset = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        doReset();

        repeat (10) applyStimulus(0, 0, 0, 0);
        checkOutput("idleUniVac", int'(uni_vacated_space), 500);
        checkOutput("idleFreeVac", int'(vacated_space), 200);

        // Continuous free-car arrivals across the afternoon capacity shifts.
        for (int i = 1; i <= 2600; i++) begin
            applyStimulus(1, 0, 0, 0);
            if (i == 200) checkOutput("freeFullAt200", int'(parked_car), 200);
            if (i == 201) checkOutput("freeIllegalAt201", int'(illegal_enter), 1);
        end
        checkOutput("freeFinal400", int'(parked_car), 400);
        checkOutput("uniVacLate300", int'(uni_vacated_space), 300);
        checkOutput("freeNoVacancy", int'(is_vacated_space), 0);

        // University lot overfilled by the capacity shrink at 14:00.
        doReset();
        repeat (480) applyStimulus(1, 1, 0, 0);
        while (mEdges < 1536) applyStimulus(0, 0, 0, 0);
        checkOutput("uniOverCount", int'(uni_parked_car), 480);
        checkOutput("uniOverVac", int'(uni_vacated_space), 0);
        repeat (3) applyStimulus(1, 1, 0, 0);
        checkOutput("uniOverIllegal", int'(illegal_enter), 1);
        repeat (81) applyStimulus(0, 0, 1, 1);
        checkOutput("uniVacAfterExits", int'(uni_vacated_space), 1);

        // Exits from empty categories, then same-cycle enter and exit.
        doReset();
        applyStimulus(0, 0, 1, 1);
        checkOutput("emptyUniExitIllegal", int'(illegal_exit), 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("emptyFreeExitIllegal", int'(illegal_exit), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("illegalExitClears", int'(illegal_exit), 0);
        repeat (5) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 1, 1);
        checkOutput("sameCycleCount", int'(uni_parked_car), 5);
        checkOutput("sameCycleNoEnterFlag", int'(illegal_enter), 0);
        checkOutput("sameCycleNoExitFlag", int'(illegal_exit), 0);

        // Random traffic long enough to reach the hour saturation at 23.
        doReset();
        for (int i = 0; i < 4200; i++) begin
            applyStimulus($urandom_range(0, 99) < 65, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 99) < 30, $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset in the middle of the clock low phase.
        #2 reset = 1'b0;
        #1;
        checkOutput("asyncUniParked", int'(uni_parked_car), 0);
        checkOutput("asyncFreeParked", int'(parked_car), 0);
        checkOutput("asyncUniVac", int'(uni_vacated_space), 500);
        checkOutput("asyncFreeVac", int'(vacated_space), 200);
        checkOutput("asyncIllegalEnter", int'(illegal_enter), 0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
